// File: rtl/ft_pkg.sv
// rtl/ft_pkg.sv - shared definitions for the FT2232H synchronous-245 transmit path
// Contents: FT_TX_* state encodings for the transmit FSM, FT_CLK_HZ (CLKOUT frequency).
// Optional feature macro used by this slice: FT_TX_STATS_EN (see ft_sync_tx.sv).
package ft_pkg;

  localparam int FT_CLK_HZ = 60_000_000;

  typedef enum logic [1:0] {
    FT_TX_IDLE = 2'd0,
    FT_TX_SEND = 2'd1,
    FT_TX_HOLD = 2'd2
  } ft_tx_state_t;

endpackage

// File: rtl/ft_byte_fifo.sv
// rtl/ft_byte_fifo.sv - single-clock show-ahead byte FIFO with occupancy count
// Ports:
//   clk, reset        clock, synchronous active-high reset (empties the FIFO)
//   push, push_data   write strobe and byte; ignored when full (fullness taken before this edge's pop)
//   pop               consume head; caller only pops when not empty
//   head              byte at the read pointer, valid whenever empty==0
//   count             occupancy 0..DEPTH
//   empty, full       occupancy flags
module ft_byte_fifo
  import ft_pkg::*;
#(
  parameter int DEPTH = 2048,
  parameter int AW    = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    head,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers are AW bits wide so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ft_sync_tx.sv
// rtl/ft_sync_tx.sv - buffers framed bytes and drives the FT2232H sync-245 write side
// Ports:
//   clk, reset          60 MHz FT CLKOUT, synchronous active-high reset
//   in_valid, in_data   framed byte stream, no backpressure
//   ft_txe_n            TXE#, low = FT accepts a byte at this edge
//   ft_wr_n, ft_data    WR# and data bus, fully registered
//   level               buffered bytes, excluding the byte held in the output register
//   overflow            sticky, set on the first dropped byte
//   drop_count/tx_count saturating statistics, live only when FT_TX_STATS_EN is defined, else 0
module ft_sync_tx
  import ft_pkg::*;
#(
  parameter int DEPTH = 2048,
  parameter int AW    = 11,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             ft_txe_n,
  output logic             ft_wr_n,
  output logic [7:0]       ft_data,
  output logic [AW:0]      level,
  output logic             overflow,
  output logic [CNT_W-1:0] drop_count,
  output logic [CNT_W-1:0] tx_count
);

  ft_tx_state_t state;

  // Input stage: one register between the framer and the buffer gives the
  // two-edge in_valid -> WR# latency and keeps framer timing off the RAM.
  logic       in_q_valid;
  logic [7:0] in_q_data;

  logic [7:0] head;
  logic       empty;
  logic       full;
  logic       drop;
  logic       consumed;
  logic       can_pop;
  logic       pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      in_q_valid <= 1'b0;
      in_q_data  <= 8'h00;
    end else begin
      in_q_valid <= in_valid;
      in_q_data  <= in_data;
    end
  end

  ft_byte_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (in_q_valid),
    .push_data (in_q_data),
    .pop       (pop),
    .head      (head),
    .count     (level),
    .empty     (empty),
    .full      (full)
  );

  assign drop     = in_q_valid && full;
  assign consumed = !ft_wr_n && !ft_txe_n;
  assign can_pop  = !empty && !ft_txe_n;
  // A new byte is loaded only when the output register is free: either idle,
  // or its current byte is being taken at this same edge.
  assign pop      = can_pop && ((state == FT_TX_IDLE) || consumed);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FT_TX_IDLE;
      ft_wr_n <= 1'b1;
      ft_data <= 8'h00;
    end else begin
      case (state)
        FT_TX_IDLE: begin
          ft_wr_n <= 1'b1;
          if (can_pop) begin
            ft_data <= head;
            ft_wr_n <= 1'b0;
            state   <= FT_TX_SEND;
          end
        end
        FT_TX_SEND, FT_TX_HOLD: begin
          if (consumed) begin
            if (can_pop) begin
              ft_data <= head;
              state   <= FT_TX_SEND;
            end else begin
              ft_wr_n <= 1'b1;
              state   <= FT_TX_IDLE;
            end
          end else begin
            state <= FT_TX_HOLD;
          end
        end
        default: begin
          ft_wr_n <= 1'b1;
          state   <= FT_TX_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

`ifdef FT_TX_STATS_EN
  logic [CNT_W-1:0] drop_q;
  logic [CNT_W-1:0] tx_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_q <= '0;
      tx_q   <= '0;
    end else begin
      if (drop && (drop_q != '1))   drop_q <= drop_q + CNT_W'(1);
      if (consumed && (tx_q != '1)) tx_q   <= tx_q + CNT_W'(1);
    end
  end

  assign drop_count = drop_q;
  assign tx_count   = tx_q;
`else
  assign drop_count = '0;
  assign tx_count   = '0;
`endif

endmodule

// File: tb/tb_ft_sync_tx.sv
// tb/tb_ft_sync_tx.sv - directed self-checking bench for ft_sync_tx (stats expectations follow FT_TX_STATS_EN)
module tb_ft_sync_tx;

  localparam int DEPTH = 2048;
  localparam int AW    = 11;
  localparam int CNT_W = 32;

`ifdef FT_TX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             ft_txe_n;
  logic             ft_wr_n;
  logic [7:0]       ft_data;
  logic [AW:0]      level;
  logic             overflow;
  logic [CNT_W-1:0] drop_count;
  logic [CNT_W-1:0] tx_count;

  int total_cnt = 0;
  int pass_cnt  = 0;

  logic [7:0] rx [$];

  ft_sync_tx #(.DEPTH(DEPTH), .AW(AW), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .ft_txe_n   (ft_txe_n),
    .ft_wr_n    (ft_wr_n),
    .ft_data    (ft_data),
    .level      (level),
    .overflow   (overflow),
    .drop_count (drop_count),
    .tx_count   (tx_count)
  );

  always #8 clk = ~clk;

  // Host model: the FT takes a byte at every rising edge where WR# and TXE# are both low.
  always @(posedge clk) begin
    if (!reset && !ft_wr_n && !ft_txe_n) rx.push_back(ft_data);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    assert (got === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    step();
    step();
    reset = 1'b0;
  endtask

  // Runs until buffer and output register are empty, bounded by max_cyc.
  task automatic drain(input string tag, input int max_cyc, input bit toggle);
    int n;
    n = 0;
    while (!(level == 0 && ft_wr_n == 1'b1 && dut.in_q_valid == 1'b0) && n < max_cyc) begin
      if (toggle) ft_txe_n = ~ft_txe_n;
      step();
      n++;
    end
    check({tag, "_drained"}, (level == 0 && ft_wr_n == 1'b1), 1);
  endtask

  initial begin
    int mism;
    logic [7:0] exp_b [3];
    ft_txe_n = 1'b1;
    do_reset();

    // Reset state
    check("rst_wr_n", ft_wr_n, 1);
    check("rst_data", ft_data, 0);
    check("rst_level", level, 0);
    check("rst_overflow", overflow, 0);
    check("rst_drop", drop_count, 0);
    check("rst_tx", tx_count, 0);

    // Test 1: 3 bytes, TXE# low, latency 2 and back-to-back output
    ft_txe_n = 1'b0;
    in_valid = 1'b1; in_data = 8'h11; step();
    check("t1_idle_e0", ft_wr_n, 1);
    in_data = 8'h22; step();
    check("t1_idle_e1", ft_wr_n, 1);
    in_data = 8'h33; step();
    in_valid = 1'b0;
    check("t1_wr0", ft_wr_n, 0);
    check("t1_d0", ft_data, 8'h11);
    step();
    check("t1_wr1", ft_wr_n, 0);
    check("t1_d1", ft_data, 8'h22);
    step();
    check("t1_wr2", ft_wr_n, 0);
    check("t1_d2", ft_data, 8'h33);
    step();
    check("t1_wr_end", ft_wr_n, 1);
    check("t1_level", level, 0);
    check("t1_rx_n", rx.size(), 3);

    // Test 2: stall with TXE# high, then release
    rx.delete();
    ft_txe_n = 1'b1;
    exp_b[0] = 8'hFE; exp_b[1] = 8'h01; exp_b[2] = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = exp_b[i]; step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) step();
    check("t2_stall_wr", ft_wr_n, 1);
    check("t2_stall_level", level, 3);
    check("t2_stall_rx", rx.size(), 0);
    ft_txe_n = 1'b0;
    drain("t2", 20, 1'b0);
    check("t2_rx_n", rx.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < rx.size()) check($sformatf("t2_rx%0d", i), rx[i], exp_b[i]);
    end

    // Test 3: 100-byte stream with TXE# toggling every cycle
    do_reset();
    rx.delete();
    ft_txe_n = 1'b0;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      ft_txe_n = ~ft_txe_n;
      step();
    end
    in_valid = 1'b0;
    drain("t3", 600, 1'b1);
    check("t3_rx_n", rx.size(), 100);
    mism = 0;
    for (int i = 0; i < rx.size() && i < 100; i++) if (rx[i] !== 8'(i)) mism++;
    check("t3_rx_mism", mism, 0);
    check("t3_tx_count", tx_count, STATS ? 100 : 0);
    check("t3_overflow", overflow, 0);

    // Test 4 (and 6 when built without stats): overflow while stalled
    do_reset();
    rx.delete();
    ft_txe_n = 1'b1;
    for (int i = 0; i < DEPTH + 5; i++) begin
      in_valid = 1'b1; in_data = 8'(i); step();
    end
    in_valid = 1'b0;
    step();
    step();
    check("t4_level", level, DEPTH);
    check("t4_overflow", overflow, 1);
    check("t4_drop", drop_count, STATS ? 5 : 0);
    check("t4_wr_stall", ft_wr_n, 1);
    ft_txe_n = 1'b0;
    drain("t4", 3 * DEPTH, 1'b0);
    check("t4_rx_n", rx.size(), DEPTH);
    mism = 0;
    for (int i = 0; i < rx.size() && i < DEPTH; i++) if (rx[i] !== 8'(i)) mism++;
    check("t4_rx_mism", mism, 0);
    check("t4_tx_count", tx_count, STATS ? DEPTH : 0);
    check("t4_overflow_sticky", overflow, 1);

    // Test 5: reset while holding a byte with 50 buffered
    do_reset();
    rx.delete();
    ft_txe_n = 1'b0;
    in_valid = 1'b1; in_data = 8'hA0; step();
    in_valid = 1'b0; step();
    step();
    check("t5_send_wr", ft_wr_n, 0);
    ft_txe_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      in_valid = 1'b1; in_data = 8'(8'hC0 + i); step();
    end
    in_valid = 1'b0;
    step();
    step();
    check("t5_hold_wr", ft_wr_n, 0);
    check("t5_hold_data", ft_data, 8'hA0);
    check("t5_hold_level", level, 50);
    rx.delete();
    reset = 1'b1;
    step();
    check("t5_rst_wr", ft_wr_n, 1);
    check("t5_rst_level", level, 0);
    check("t5_rst_overflow", overflow, 0);
    reset = 1'b0;
    ft_txe_n = 1'b0;
    mism = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (ft_wr_n !== 1'b1) mism++;
    end
    check("t5_no_stale_wr", mism, 0);
    check("t5_no_stale_rx", rx.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
